// File: rtl/riscv32ima_fetch_if.sv
// Bundle of the fetch stage's instruction-memory, decoder and redirect signals.
// The master side is the fetch stage; the slave side is its environment.
interface riscv32ima_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  wback_pc_wen;
  logic [ADDR_WIDTH-1:0] wback_pc;

  modport master (
    output imem_req_valid, imem_req_addr, fetch_valid, fetch_address, fetch_data,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, fetch_ready,
           wback_pc_wen, wback_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fetch_valid, fetch_address, fetch_data,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, fetch_ready,
           wback_pc_wen, wback_pc
  );
endinterface

// File: rtl/riscv32ima_fetch.sv
// Instruction fetch stage: one outstanding word read, instruction handed to the decoder
// on a valid/ready handshake, PC redirect squashes any in-flight or held fetch.
module riscv32ima_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  nrst,
  riscv32ima_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic                  discard_q, discard_d;
  logic                  req_valid_q, req_valid_d;
  logic                  fvalid_q, fvalid_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_s;
  logic                  req_fire_s;
  logic                  fetch_fire_s;

  assign redirect_pc_s = bus.wback_pc & ~ADDR_WIDTH'(32'd3);
  assign req_fire_s    = req_valid_q & bus.imem_req_ready;
  assign fetch_fire_s  = fvalid_q & bus.fetch_ready;

  // Next-state and next-output logic; redirect overrides the pc+4 increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issued_d  = issued_q;
    discard_d = discard_q;
    fvalid_d  = fvalid_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_fire_s) begin
          issued_d  = pc_q;
          pc_d      = pc_q + ADDR_WIDTH'(32'd4);
          discard_d = bus.wback_pc_wen;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (discard_q || bus.wback_pc_wen) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            fvalid_d = 1'b1;
            faddr_d  = issued_q;
            fdata_d  = {{(DATA_WIDTH-INST_WIDTH){1'b0}}, bus.imem_rsp_data};
            state_d  = ST_HOLD;
          end
        end else if (bus.wback_pc_wen) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      ST_HOLD: begin
        // A redirect without handshake flushes the held instruction.
        if (fetch_fire_s || bus.wback_pc_wen) begin
          fvalid_d = 1'b0;
          state_d  = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.wback_pc_wen) begin
      pc_d = redirect_pc_s;
    end else begin
      pc_d = pc_d;
    end

    req_valid_d = (state_d == ST_REQ);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      issued_q    <= '0;
      discard_q   <= 1'b0;
      req_valid_q <= 1'b0;
      fvalid_q    <= 1'b0;
      faddr_q     <= '0;
      fdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_q    <= issued_d;
      discard_q   <= discard_d;
      req_valid_q <= req_valid_d;
      fvalid_q    <= fvalid_d;
      faddr_q     <= faddr_d;
      fdata_q     <= fdata_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.fetch_valid    = fvalid_q;
  assign bus.fetch_address  = faddr_q;
  assign bus.fetch_data     = fdata_q;

endmodule

// File: tb/tb_riscv32ima_fetch.sv
// Bench for riscv32ima_fetch: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of which fetches must reach the decoder.
module tb_riscv32ima_fetch;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  riscv32ima_fetch_if dif ();

  riscv32ima_fetch dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] model_pc;
  logic        outstanding;
  logic        live;
  logic [31:0] oaddr;
  logic        presenting;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic        started;
  int          delivered;
  logic [31:0] acc_log[$];

  // Memory model state
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          rsp_delay;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_pc    = 32'h0000_0000;
    outstanding = 1'b0;
    live        = 1'b0;
    presenting  = 1'b0;
    started     = 1'b0;
    mem_pend    = 1'b0;
    mem_cnt     = 0;
    dif.imem_rsp_valid = 1'b0;
  endtask

  task automatic cycle();
    logic        acc;
    logic        hs;
    logic        wen;
    logic        pres_old;
    logic [31:0] a;
    logic [31:0] tgt;
    if (dif.imem_req_valid)
      chk("req_addr", {32'h0, dif.imem_req_addr}, {32'h0, model_pc});
    if (dif.fetch_valid) begin
      chk("fetch_address", {32'h0, dif.fetch_address}, {32'h0, exp_addr});
      chk("fetch_data", dif.fetch_data, {32'h0, exp_data});
    end
    acc      = dif.imem_req_valid & dif.imem_req_ready;
    hs       = dif.fetch_valid & dif.fetch_ready;
    wen      = dif.wback_pc_wen;
    tgt      = dif.wback_pc;
    a        = dif.imem_req_addr;
    pres_old = presenting;

    if (pres_old && (hs || wen)) begin
      presenting = 1'b0;
      if (hs) delivered++;
    end
    if (outstanding && dif.imem_rsp_valid) begin
      outstanding = 1'b0;
      if (live && !wen) begin
        presenting = 1'b1;
        exp_addr   = oaddr;
        exp_data   = dif.imem_rsp_data;
      end
    end else if (outstanding && wen) begin
      live = 1'b0;
    end
    if (acc) begin
      outstanding = 1'b1;
      live        = !wen;
      oaddr       = a;
      acc_log.push_back(a);
    end
    if (wen) model_pc = {tgt[31:2], 2'b00};
    else if (acc) model_pc = a + 32'd4;

    @(posedge clk);
    #1;
    started = 1'b1;
    chk("fetch_valid", {63'h0, dif.fetch_valid}, {63'h0, presenting});
    chk("req_valid", {63'h0, dif.imem_req_valid}, {63'h0, (!outstanding && !presenting)});

    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = rsp_delay;
    end
    if (mem_pend && mem_cnt == 0) begin
      dif.imem_rsp_valid = 1'b1;
      dif.imem_rsp_data  = memf(mem_addr);
      mem_pend = 1'b0;
    end else begin
      dif.imem_rsp_valid = 1'b0;
      if (mem_pend) mem_cnt--;
    end
    dif.wback_pc_wen = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    dif.wback_pc_wen = 1'b1;
    dif.wback_pc     = t;
    cycle();
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 40 && acc_log.size() < n; i++) cycle();
    chk(tag, {63'h0, (acc_log.size() >= n)}, 64'h1);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    delivered = 0;
    rsp_delay = 0;
    nrst = 1'b0;
    dif.imem_req_ready = 1'b0;
    dif.imem_rsp_data  = 32'h0;
    dif.fetch_ready    = 1'b0;
    dif.wback_pc_wen   = 1'b0;
    dif.wback_pc       = 32'h0;
    model_reset();

    // Reset state
    #12;
    chk("rst_req_valid", {63'h0, dif.imem_req_valid}, 64'h0);
    chk("rst_fetch_valid", {63'h0, dif.fetch_valid}, 64'h0);
    chk("rst_fetch_address", {32'h0, dif.fetch_address}, 64'h0);
    chk("rst_fetch_data", dif.fetch_data, 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("idle_req_valid", {63'h0, dif.imem_req_valid}, 64'h0);

    // 1: sequential fetch with a 0-wait memory
    dif.imem_req_ready = 1'b1;
    dif.fetch_ready    = 1'b1;
    for (int i = 0; i < 30 && delivered < 3; i++) cycle();
    chk("t1_delivered", {63'h0, (delivered >= 3)}, 64'h1);
    chk("t1_addr0", {32'h0, acc_log[0]}, 64'h0);
    chk("t1_addr1", {32'h0, acc_log[1]}, 64'h4);
    chk("t1_addr2", {32'h0, acc_log[2]}, 64'h8);

    // 2: decoder backpressure in HOLD
    dif.fetch_ready = 1'b0;
    for (int i = 0; i < 20 && !presenting; i++) cycle();
    chk("t2_hold", {63'h0, presenting}, 64'h1);
    n = acc_log.size();
    for (int i = 0; i < 5; i++) cycle();
    chk("t2_no_req", n, acc_log.size());
    dif.fetch_ready = 1'b1;
    cycle();
    chk("t2_req_after", {63'h0, dif.imem_req_valid}, 64'h1);
    chk("t2_req_addr", {32'h0, dif.imem_req_addr}, {32'h0, acc_log[n-1] + 32'd4});

    // 3: redirect in WAIT drops the old response
    rsp_delay = 2;
    for (int i = 0; i < 20 && !outstanding; i++) cycle();
    redirect(32'h0000_0103);
    n = acc_log.size();
    wait_acc(n + 1, "t3_timeout");
    chk("t3_target", {32'h0, acc_log[n]}, 64'h100);

    // 4a: redirect in the same cycle the request is accepted
    rsp_delay = 0;
    for (int i = 0; i < 20 && !dif.imem_req_valid; i++) cycle();
    redirect(32'h0000_0200);
    n = acc_log.size();
    wait_acc(n + 1, "t4a_timeout");
    chk("t4a_target", {32'h0, acc_log[n]}, 64'h200);

    // 4b: redirect in the same cycle as the response
    rsp_delay = 1;
    for (int i = 0; i < 20 && !dif.imem_rsp_valid; i++) cycle();
    chk("t4b_rsp_seen", {63'h0, dif.imem_rsp_valid}, 64'h1);
    redirect(32'h0000_0300);
    n = acc_log.size();
    wait_acc(n + 1, "t4b_timeout");
    chk("t4b_target", {32'h0, acc_log[n]}, 64'h300);

    // 5: PC wrap at the top of the address space
    rsp_delay = 0;
    dif.imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !dif.imem_req_valid; i++) cycle();
    redirect(32'hFFFF_FFFC);
    dif.imem_req_ready = 1'b1;
    n = acc_log.size();
    wait_acc(n + 2, "t5_timeout");
    chk("t5_top", {32'h0, acc_log[n]}, 64'hFFFF_FFFC);
    chk("t5_wrap", {32'h0, acc_log[n+1]}, 64'h0);

    // 6: asynchronous reset in HOLD
    dif.fetch_ready = 1'b0;
    for (int i = 0; i < 20 && !presenting; i++) cycle();
    chk("t6_hold", {63'h0, dif.fetch_valid}, 64'h1);
    #3;
    nrst = 1'b0;
    #1;
    chk("t6_fetch_valid", {63'h0, dif.fetch_valid}, 64'h0);
    chk("t6_req_valid", {63'h0, dif.imem_req_valid}, 64'h0);
    chk("t6_fetch_data", dif.fetch_data, 64'h0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("t6_idle", {63'h0, dif.imem_req_valid}, 64'h0);
    cycle();
    chk("t6_req_reset_pc", {32'h0, dif.imem_req_addr}, 64'h0);

    // Random traffic
    n = delivered;
    for (int i = 0; i < 2000; i++) begin
      dif.imem_req_ready = ($urandom_range(0, 3) != 0);
      dif.fetch_ready    = ($urandom_range(0, 2) != 0);
      rsp_delay          = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) begin
        dif.wback_pc_wen = 1'b1;
        dif.wback_pc     = $urandom;
      end
      cycle();
    end
    chk("rand_progress", {63'h0, (delivered - n > 50)}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
